rc_share_arb: RTL and testbench
===============================

Name: rc_share_arb

Overview:
- Shares one route-computation datapath between NUM_REQ input channels of a bufferless multicast router.
- Arbitrates flit headers from the requesters with round-robin ordering.
- Registers the granted header into the route-computation inputs, then captures the returned prefer-port vector.
- Returns the result, tagged with the requester id, over a valid/ready response channel.
- Two-stage pipeline (S1 = header stage, S2 = response stage); one header per cycle at full throughput.

Parameters:
NUM_REQ, 4, number of requesting input channels (>=2)
REQ_ID_WIDTH, 2, width of requester index, = clog2(NUM_REQ)
DST_WIDTH, 6, unicast destination width
DST_LIST_WIDTH, 16, multicast destination bitmap width
NUM_PORT, 5, width of prefer-port vector

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester header valid
req_ready  out  NUM_REQ  one-hot grant/accept, combinational
req_dst  in  NUM_REQ*DST_WIDTH  packed unicast dst, requester i at slice i
req_dst_list  in  NUM_REQ*DST_LIST_WIDTH  packed multicast bitmaps
req_mc  in  NUM_REQ  1 = multicast header
rc_dst  out  DST_WIDTH  to route-compute datapath
rc_dst_list  out  DST_LIST_WIDTH  to route-compute datapath
rc_mc  out  1  to route-compute datapath
rc_ppv  in  NUM_PORT  combinational result from route-compute datapath
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  REQ_ID_WIDTH  requester index of response
rsp_ppv  out  NUM_PORT  prefer-port vector
rsp_err  out  1  multicast header with empty dst_list

Behaviour:
Reset:
- Clock is clk; reset is reset_n, asynchronous, active-low.
- Reset clears s1_valid, s2_valid and the RR pointer (ptr=0).
- rsp_valid, rsp_id, rsp_ppv and rsp_err reset to 0.
- rc_* outputs reset to 0; req_ready is 0 while in reset.
- Reset mid-operation flushes both stages; in-flight headers are lost, with no partial response.

Pipeline control:
- s2_adv = s1_valid & (~s2_valid | rsp_ready).
- s1_free = ~s1_valid | s2_adv.

Arbitration:
- If s1_free, grant the first requester with req_valid=1, searching ptr, ptr+1, … modulo NUM_REQ.
- req_ready is one-hot on the granted index; it is all-zero if nothing is valid or s1_free=0.
- A header is accepted when req_valid[i] & req_ready[i] at a rising edge.
- On accept, ptr <= grant+1 mod NUM_REQ. Otherwise ptr holds.
- req_ready must not depend on rsp_ready when s2_valid=0.

S1 stage:
- On accept, S1 loads dst, dst_list, mc and id of the winner; s1_valid <= 1.
- If s2_adv occurs with no accept, s1_valid <= 0.
- rc_dst, rc_dst_list and rc_mc are driven from S1 while s1_valid=1, and are forced to 0 when s1_valid=0.

S2 stage:
- On s2_adv, S2 captures rc_ppv, the S1 id and err = s1_mc & (s1_dst_list==0).
- When err=1, rsp_ppv is captured as 0.
- s2_valid <= 1 on s2_adv; s2_valid <= 0 on rsp handshake with no s2_adv.
- rsp_* hold stable while rsp_valid & ~rsp_ready.

Timing:
- Latency: accept at edge k gives rsp_valid=1 after edge k+1.
- Throughput: 1 header/cycle while rsp_ready=1.
- Backpressure: with rsp_ready=0, S2 holds and S1 still fills once. A third header is not granted until rsp_ready rises.
- Simultaneous rsp handshake and s2_adv: S2 reloads and rsp_valid stays 1.

Fairness:
- Any continuously valid requester is granted within NUM_REQ accepts.

Test Plan:
- Single request: after reset, req_valid=0b0100, req_dst[2]=6'h2A, mc=0, rc_ppv stub returns 5'b00010. Required: req_ready=0b0100 in the same cycle; rsp_valid=1 two edges later with rsp_id=2, rsp_ppv=00010, rsp_err=0.
- Round robin: req_valid=0b1111 held, rsp_ready=1. Required: grants in order 0,1,2,3,0,… on consecutive cycles; ptr wraps from 3 to 0.
- Backpressure: all requesters valid, rsp_ready=0. Required: exactly two accepts, then req_ready=0 and rsp_* stable. Raising rsp_ready for one cycle releases exactly one response and one new accept.
- Multicast empty list: req_mc[1]=1, req_dst_list[1]=0. Required: rsp_err=1, rsp_ppv=0, rsp_id=1. With dst_list=16'h0011, rsp_err=0 and rsp_ppv=rc_ppv.
- Reset mid-flight: S1 and S2 both valid, then assert reset_n=0 asynchronously between edges. Required: rsp_valid=0 and rc_*=0 immediately; after release the first grant goes to index 0.
- Skip invalid: ptr=3 and req_valid=0b0010. Required: grant index 1, and the next ptr is 2.

Source files
------------

// File: rtl/rc_share_arb.sv
// Shares one route-compute datapath among NUM_REQ header requesters (round-robin, id-tagged responses).
// Latency: a header accepted at edge k is presented on rsp_* after edge k+1; one header per cycle sustained.
// Backpressure: rsp_ready low stalls S2, S1 fills once more, then req_ready drops to zero until drained.
module rc_share_arb #(
  parameter int NUM_REQ        = 4,
  parameter int REQ_ID_WIDTH   = 2,
  parameter int DST_WIDTH      = 6,
  parameter int DST_LIST_WIDTH = 16,
  parameter int NUM_PORT       = 5
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*DST_WIDTH-1:0]       req_dst,
  input  logic [NUM_REQ*DST_LIST_WIDTH-1:0]  req_dst_list,
  input  logic [NUM_REQ-1:0]                 req_mc,
  output logic [DST_WIDTH-1:0]               rc_dst,
  output logic [DST_LIST_WIDTH-1:0]          rc_dst_list,
  output logic                               rc_mc,
  input  logic [NUM_PORT-1:0]                rc_ppv,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic [REQ_ID_WIDTH-1:0]            rsp_id,
  output logic [NUM_PORT-1:0]                rsp_ppv,
  output logic                               rsp_err
);

  typedef struct packed {
    logic [DST_WIDTH-1:0]      dst;
    logic [DST_LIST_WIDTH-1:0] dst_list;
    logic                      mc;
    logic [REQ_ID_WIDTH-1:0]   id;
  } hdr_t;

  logic [REQ_ID_WIDTH-1:0] ptr;
  logic [REQ_ID_WIDTH-1:0] grant_idx;
  logic [REQ_ID_WIDTH-1:0] ptr_nxt;
  logic                    grant_vld;
  logic                    accept;
  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s2_adv;
  logic                    s1_free;
  logic                    s1_err;
  hdr_t                    s1_hdr;
  hdr_t                    win_hdr;

  assign s2_adv  = s1_valid & (~s2_valid | rsp_ready);
  assign s1_free = ~s1_valid | s2_adv;

  // Search starts at ptr and wraps; first valid requester wins.
  always_comb begin
    int j;
    grant_vld = 1'b0;
    grant_idx = '0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!grant_vld && req_valid[j]) begin
        grant_vld = 1'b1;
        grant_idx = REQ_ID_WIDTH'(j);
      end
    end
  end

  assign accept    = grant_vld & s1_free & reset_n;
  assign req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
  assign ptr_nxt   = (grant_idx == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                               : grant_idx + REQ_ID_WIDTH'(1);

  always_comb begin
    win_hdr          = '0;
    win_hdr.dst      = req_dst[int'(grant_idx)*DST_WIDTH +: DST_WIDTH];
    win_hdr.dst_list = req_dst_list[int'(grant_idx)*DST_LIST_WIDTH +: DST_LIST_WIDTH];
    win_hdr.mc       = req_mc[grant_idx];
    win_hdr.id       = grant_idx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_hdr   <= '0;
    end else if (accept) begin
      ptr      <= ptr_nxt;
      s1_valid <= 1'b1;
      s1_hdr   <= win_hdr;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  assign rc_dst      = s1_valid ? s1_hdr.dst      : '0;
  assign rc_dst_list = s1_valid ? s1_hdr.dst_list : '0;
  assign rc_mc       = s1_valid & s1_hdr.mc;

  // A multicast header with no destinations has no meaningful route; flag it and drop the ppv.
  assign s1_err = s1_hdr.mc & (s1_hdr.dst_list == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      rsp_id   <= '0;
      rsp_ppv  <= '0;
      rsp_err  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= 1'b1;
      rsp_id   <= s1_hdr.id;
      rsp_ppv  <= s1_err ? '0 : rc_ppv;
      rsp_err  <= s1_err;
    end else if (rsp_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign rsp_valid = s2_valid;

endmodule

// File: tb/tb_rc_share_arb.sv
// Directed bench for rc_share_arb with a combinational route-compute stub.
module tb_rc_share_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_dst;
  logic [63:0] req_dst_list;
  logic [3:0]  req_mc;
  logic [5:0]  rc_dst;
  logic [15:0] rc_dst_list;
  logic        rc_mc;
  logic [4:0]  rc_ppv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [4:0]  rsp_ppv;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  rc_share_arb dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_dst_list(req_dst_list), .req_mc(req_mc),
    .rc_dst(rc_dst), .rc_dst_list(rc_dst_list), .rc_mc(rc_mc), .rc_ppv(rc_ppv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_ppv(rsp_ppv), .rsp_err(rsp_err)
  );

  // Route-compute stub: unicast ppv = dst[4:0]^01000, multicast ppv = list[4:0]^10100.
  assign rc_ppv = rc_mc ? (rc_dst_list[4:0] ^ 5'b10100) : (rc_dst[4:0] ^ 5'b01000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Requester dst values 0..3: 07, 15, 2A, 33 -> unicast ppv 01111, 11101, 00010, 11011.
  logic [3:0] rr_rdy [4];
  logic [1:0] rr_id  [4];
  logic [4:0] rr_ppv [4];

  initial begin
    rr_rdy = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    rr_id  = '{2'd1, 2'd2, 2'd3, 2'd0};
    rr_ppv = '{5'b11101, 5'b00010, 5'b11011, 5'b01111};

    reset_n      = 1'b0;
    req_valid    = 4'b1111;
    req_dst      = {6'h33, 6'h2A, 6'h15, 6'h07};
    req_dst_list = '0;
    req_mc       = '0;
    rsp_ready    = 1'b1;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rc_dst", 32'(rc_dst), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_ppv", 32'(rsp_ppv), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    req_valid = 4'b0000;
    step();
    step();
    reset_n = 1'b1;

    // Single request from requester 2
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    #1;
    chk("single_rc_dst", 32'(rc_dst), 32'h2A);
    chk("single_rc_mc", 32'(rc_mc), 32'h0);
    chk("single_rsp_early", 32'(rsp_valid), 32'h0);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_id", 32'(rsp_id), 32'h2);
    chk("single_rsp_ppv", 32'(rsp_ppv), 32'h02);
    chk("single_rsp_err", 32'(rsp_err), 32'h0);
    chk("single_rc_idle", 32'(rc_dst), 32'h0);

    // ptr is 3; only requester 1 valid
    req_valid = 4'b0010;
    #1;
    chk("skip_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1111;
    #1;
    chk("skip_next_ptr", 32'(req_ready), 32'h4);
    chk("skip_rsp_drained", 32'(rsp_valid), 32'h0);

    // Round robin at full throughput, wrapping 3 -> 0
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_ready", 32'(req_ready), 32'(rr_rdy[i]));
      chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(rr_id[i]));
      chk("rr_rsp_ppv", 32'(rsp_ppv), 32'(rr_ppv[i]));
    end

    // Drain (S1 holds requester 1)
    req_valid = 4'b0000;
    step();
    chk("drain_rsp_id", 32'(rsp_id), 32'h1);
    chk("drain_rsp_ppv", 32'(rsp_ppv), 32'h1D);
    step();
    chk("drain_empty", 32'(rsp_valid), 32'h0);

    // Backpressure from empty pipe, ptr = 2
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'h4);
    step();
    chk("bp_ready1", 32'(req_ready), 32'h8);
    step();
    chk("bp_ready_stall", 32'(req_ready), 32'h0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_rsp_id", 32'(rsp_id), 32'h2);
    chk("bp_rsp_ppv", 32'(rsp_ppv), 32'h02);
    step();
    chk("bp_hold_ready", 32'(req_ready), 32'h0);
    chk("bp_hold_id", 32'(rsp_id), 32'h2);
    chk("bp_hold_ppv", 32'(rsp_ppv), 32'h02);
    chk("bp_hold_rc_dst", 32'(rc_dst), 32'h33);
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h1);
    step();
    rsp_ready = 1'b0;
    #1;
    chk("bp_reload_valid", 32'(rsp_valid), 32'h1);
    chk("bp_reload_id", 32'(rsp_id), 32'h3);
    chk("bp_reload_ppv", 32'(rsp_ppv), 32'h1B);
    chk("bp_one_accept", 32'(req_ready), 32'h0);
    chk("bp_s1_next", 32'(rc_dst), 32'h07);
    step();
    chk("bp_one_release", 32'(rsp_id), 32'h3);

    // Asynchronous reset between edges with both stages full
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_rc_dst", 32'(rc_dst), 32'h0);
    chk("mid_rst_rc_list", 32'(rc_dst_list), 32'h0);
    chk("mid_rst_rc_mc", 32'(rc_mc), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    step();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0000;
    #1;
    chk("post_rst_rc_dst", 32'(rc_dst), 32'h07);
    step();
    chk("post_rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("post_rst_rsp_ppv", 32'(rsp_ppv), 32'h0F);

    // Multicast with empty list from requester 1 (ptr = 1)
    req_mc    = 4'b0010;
    req_valid = 4'b0010;
    #1;
    chk("mc_empty_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    #1;
    chk("mc_empty_rc_mc", 32'(rc_mc), 32'h1);
    step();
    chk("mc_empty_err", 32'(rsp_err), 32'h1);
    chk("mc_empty_ppv", 32'(rsp_ppv), 32'h0);
    chk("mc_empty_id", 32'(rsp_id), 32'h1);

    // Multicast with a non-empty list (ptr = 2, so requester 1 is reached by wrap)
    req_dst_list = {16'h0000, 16'h0000, 16'h0011, 16'h0000};
    req_valid    = 4'b0010;
    #1;
    chk("mc_list_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    #1;
    chk("mc_list_rc_list", 32'(rc_dst_list), 32'h0011);
    step();
    chk("mc_list_err", 32'(rsp_err), 32'h0);
    chk("mc_list_ppv", 32'(rsp_ppv), 32'h05);
    chk("mc_list_id", 32'(rsp_id), 32'h1);
    step();
    chk("final_idle", 32'(rsp_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
